// File: rtl/flght_cntrl_pkg.sv
// Shared types, default constants and saturation helpers
// for the flght_cntrl_gen flight controller.
package flght_cntrl_pkg;

  typedef enum logic [1:0] {OFF, RAMP, RUN, CAL} state_t;

  localparam int ERR_W_D         = 10;
  localparam int D_QUEUE_DEPTH_D = 12;
  localparam int D_W_D           = 7;
  localparam int P_NUM_D         = 5;
  localparam int P_SHIFT_D       = 3;
  localparam int D_COEF_D        = 9;
  localparam int SPD_W_D         = 11;
  localparam int MIN_RUN_SPEED_D = 416;
  localparam int CAL_SPEED_D     = 432;
  localparam int RAMP_STEP_D     = 64;

  typedef struct packed {
    logic [15:0] err_p;
    logic [15:0] err_r;
    logic [15:0] err_y;
    logic [15:0] dd_p;
    logic [15:0] dd_r;
    logic [15:0] dd_y;
    logic [8:0]  thrst;
  } s1_s2_t;

  function automatic logic signed [31:0] sat_s(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [31:0] clamp_u(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    hi = (32'sd1 <<< w) - 32'sd1;
    if (v < 32'sd0) return 32'sd0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/flght_cntrl_gen_err_queue.sv
// Circular history of saturated errors; dout is the
// entry written DEPTH pushes ago once full is high.
module err_queue #(
  parameter int DEPTH = 12,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   fill;

  assign dout = mem[ptr];
  assign full = (fill == (PW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      fill <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      ptr  <= '0;
      fill <= '0;
    end else if (push) begin
      mem[ptr] <= din;
      if (ptr == PW'(DEPTH - 1)) ptr <= '0;
      else ptr <= ptr + 1'b1;
      if (!full) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/flght_cntrl_gen.sv
// Quadcopter PD controller: error/D stage, mix stage and
// arm/ramp/run/cal sequencing into four motor speeds.
module flght_cntrl_gen
  import flght_cntrl_pkg::*;
#(
  parameter int ERR_W         = ERR_W_D,
  parameter int D_QUEUE_DEPTH = D_QUEUE_DEPTH_D,
  parameter int D_W           = D_W_D,
  parameter int P_NUM         = P_NUM_D,
  parameter int P_SHIFT       = P_SHIFT_D,
  parameter int D_COEF        = D_COEF_D,
  parameter int SPD_W         = SPD_W_D,
  parameter int MIN_RUN_SPEED = MIN_RUN_SPEED_D,
  parameter int CAL_SPEED     = CAL_SPEED_D,
  parameter int RAMP_STEP     = RAMP_STEP_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic              inertial_cal,
  input  logic              motors_off,
  input  logic signed [15:0] d_ptch,
  input  logic signed [15:0] d_roll,
  input  logic signed [15:0] d_yaw,
  input  logic signed [15:0] ptch,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] yaw,
  input  logic [8:0]        thrst,
  output logic [SPD_W-1:0]  frnt_spd,
  output logic [SPD_W-1:0]  bck_spd,
  output logic [SPD_W-1:0]  lft_spd,
  output logic [SPD_W-1:0]  rght_spd,
  output logic              spd_vld,
  output logic              armed
);

  state_t state, state_n;

  logic [SPD_W-1:0]  ramp_spd, ramp_n;
  logic [SPD_W-1:0]  spd [4];
  logic [SPD_W-1:0]  spd_n [4];
  logic [SPD_W-1:0]  mix_c [4];
  logic              spd_vld_n;
  logic              s1_vld;
  s1_s2_t            s1, s1_n;
  logic signed [15:0] meas [3];
  logic signed [15:0] des [3];
  logic signed [15:0] e_sat [3];
  logic signed [15:0] dd [3];
  logic [ERR_W-1:0]  q_old [3];
  logic              q_full [3];
  logic              q_push;
  logic signed [31:0] base, t_p, t_r, t_y;
  logic signed [31:0] mix [4];
  logic [31:0]       rs;

  assign meas[0] = ptch;
  assign meas[1] = roll;
  assign meas[2] = yaw;
  assign des[0]  = d_ptch;
  assign des[1]  = d_roll;
  assign des[2]  = d_yaw;

  assign q_push = vld && !motors_off && (state != OFF);

  for (genvar i = 0; i < 3; i++) begin : g_q
    err_queue #(
      .DEPTH(D_QUEUE_DEPTH),
      .W    (ERR_W)
    ) u_q (
      .clk  (clk),
      .rst_n(rst_n),
      .push (q_push),
      .clr  (motors_off),
      .din  (e_sat[i][ERR_W-1:0]),
      .dout (q_old[i]),
      .full (q_full[i])
    );
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      e_sat[i] = 16'(sat_s(32'(meas[i]) - 32'(des[i]), ERR_W));
      dd[i]    = '0;
      if (q_full[i]) begin
        dd[i] = 16'(sat_s(32'(e_sat[i])
                - 32'(signed'(q_old[i])), D_W));
      end
    end
    s1_n       = '0;
    s1_n.err_p = e_sat[0];
    s1_n.err_r = e_sat[1];
    s1_n.err_y = e_sat[2];
    s1_n.dd_p  = dd[0];
    s1_n.dd_r  = dd[1];
    s1_n.dd_y  = dd[2];
    s1_n.thrst = thrst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= vld && !motors_off;
      if (vld && !motors_off) s1 <= s1_n;
    end
  end

  // P floors via arithmetic shift; sums kept wide before clamping
  always_comb begin
    base = MIN_RUN_SPEED + signed'(32'(s1.thrst));
    t_p  = ((32'(signed'(s1.err_p)) * P_NUM) >>> P_SHIFT)
         + 32'(signed'(s1.dd_p)) * D_COEF;
    t_r  = ((32'(signed'(s1.err_r)) * P_NUM) >>> P_SHIFT)
         + 32'(signed'(s1.dd_r)) * D_COEF;
    t_y  = ((32'(signed'(s1.err_y)) * P_NUM) >>> P_SHIFT)
         + 32'(signed'(s1.dd_y)) * D_COEF;
    mix[0] = base + t_p - t_y;
    mix[1] = base - t_p - t_y;
    mix[2] = base - t_r + t_y;
    mix[3] = base + t_r + t_y;
    for (int i = 0; i < 4; i++) begin
      mix_c[i] = SPD_W'(clamp_u(mix[i], SPD_W));
    end
  end

  always_comb begin
    state_n   = state;
    ramp_n    = ramp_spd;
    spd_vld_n = 1'b0;
    for (int i = 0; i < 4; i++) spd_n[i] = spd[i];
    rs = 32'(ramp_spd) + 32'(RAMP_STEP);
    if (rs > 32'(MIN_RUN_SPEED)) rs = 32'(MIN_RUN_SPEED);
    if (motors_off) begin
      state_n = OFF;
      ramp_n  = '0;
      for (int i = 0; i < 4; i++) spd_n[i] = '0;
    end else if (s1_vld) begin
      unique case (state)
        OFF: begin
          if (inertial_cal) begin
            state_n = CAL;
          end else begin
            state_n = RAMP;
            ramp_n  = '0;
          end
        end
        RAMP: begin
          spd_vld_n = 1'b1;
          if (inertial_cal) begin
            state_n = CAL;
            for (int i = 0; i < 4; i++)
              spd_n[i] = SPD_W'(CAL_SPEED);
          end else begin
            ramp_n = SPD_W'(rs);
            for (int i = 0; i < 4; i++)
              spd_n[i] = SPD_W'(rs);
            if (rs == 32'(MIN_RUN_SPEED)) state_n = RUN;
          end
        end
        RUN: begin
          spd_vld_n = 1'b1;
          if (inertial_cal) begin
            state_n = CAL;
            for (int i = 0; i < 4; i++)
              spd_n[i] = SPD_W'(CAL_SPEED);
          end else begin
            for (int i = 0; i < 4; i++) spd_n[i] = mix_c[i];
          end
        end
        CAL: begin
          spd_vld_n = 1'b1;
          if (inertial_cal) begin
            for (int i = 0; i < 4; i++)
              spd_n[i] = SPD_W'(CAL_SPEED);
          end else begin
            state_n = RUN;
            for (int i = 0; i < 4; i++) spd_n[i] = mix_c[i];
          end
        end
        default: state_n = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      ramp_spd <= '0;
      spd_vld  <= 1'b0;
      for (int i = 0; i < 4; i++) spd[i] <= '0;
    end else begin
      state    <= state_n;
      ramp_spd <= ramp_n;
      spd_vld  <= spd_vld_n;
      for (int i = 0; i < 4; i++) spd[i] <= spd_n[i];
    end
  end

  assign frnt_spd = spd[0];
  assign bck_spd  = spd[1];
  assign lft_spd  = spd[2];
  assign rght_spd = spd[3];
  assign armed    = (state != OFF);

endmodule

// File: tb/tb_flght_cntrl_gen.sv
// Directed table-driven bench for flght_cntrl_gen.
module tb_flght_cntrl_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld = 1'b0;
  logic inertial_cal = 1'b0;
  logic motors_off = 1'b1;
  logic signed [15:0] d_ptch = '0;
  logic signed [15:0] d_roll = '0;
  logic signed [15:0] d_yaw = '0;
  logic signed [15:0] ptch = '0;
  logic signed [15:0] roll = '0;
  logic signed [15:0] yaw = '0;
  logic [8:0] thrst = '0;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic spd_vld, armed;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flght_cntrl_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld         (vld),
    .inertial_cal(inertial_cal),
    .motors_off  (motors_off),
    .d_ptch      (d_ptch),
    .d_roll      (d_roll),
    .d_yaw       (d_yaw),
    .ptch        (ptch),
    .roll        (roll),
    .yaw         (yaw),
    .thrst       (thrst),
    .frnt_spd    (frnt_spd),
    .bck_spd     (bck_spd),
    .lft_spd     (lft_spd),
    .rght_spd    (rght_spd),
    .spd_vld     (spd_vld),
    .armed       (armed)
  );

  typedef struct {
    int thr;
    int p;
    int dp;
    int r;
    int y;
    bit cal;
    int f;
    int b;
    int l;
    int rt;
  } vec_t;

  vec_t va [20];
  vec_t vb [14];
  vec_t zv;

  function automatic vec_t mk(
    input int thr, input int p, input int dp,
    input int r, input int y, input bit cal,
    input int f, input int b, input int l, input int rt
  );
    vec_t v;
    v.thr = thr; v.p = p; v.dp = dp; v.r = r; v.y = y;
    v.cal = cal; v.f = f; v.b = b; v.l = l; v.rt = rt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    thrst        = 9'(v.thr);
    ptch         = 16'(v.p);
    d_ptch       = 16'(v.dp);
    roll         = 16'(v.r);
    d_roll       = '0;
    yaw          = 16'(v.y);
    d_yaw        = '0;
    inertial_cal = v.cal;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int k;
    bit got;
    @(negedge clk);
    set_in(v);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    got = 1'b0;
    k = 0;
    while (!got && k < 4) begin
      @(negedge clk);
      if (spd_vld) got = 1'b1;
      else k++;
    end
    chk({nm, " pulse"}, int'(got), 1);
    chk({nm, " lat"}, k + 2, 2);
    chk({nm, " frnt"}, int'(frnt_spd), v.f);
    chk({nm, " bck"}, int'(bck_spd), v.b);
    chk({nm, " lft"}, int'(lft_spd), v.l);
    chk({nm, " rght"}, int'(rght_spd), v.rt);
    @(negedge clk);
    chk({nm, " width"}, int'(spd_vld), 0);
  endtask

  task automatic vld_nopulse(input string nm, input vec_t v);
    int n;
    @(negedge clk);
    set_in(v);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (spd_vld) n++;
    end
    chk({nm, " nopulse"}, n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    zv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    va[0]  = mk(0, 0, 0, 0, 0, 0, 64, 64, 64, 64);
    va[1]  = mk(0, 0, 0, 0, 0, 0, 128, 128, 128, 128);
    va[2]  = mk(0, 0, 0, 0, 0, 0, 192, 192, 192, 192);
    va[3]  = mk(0, 0, 0, 0, 0, 0, 256, 256, 256, 256);
    va[4]  = mk(0, 0, 0, 0, 0, 0, 320, 320, 320, 320);
    va[5]  = mk(0, 0, 0, 0, 0, 0, 384, 384, 384, 384);
    va[6]  = mk(0, 0, 0, 0, 0, 0, 416, 416, 416, 416);
    va[7]  = mk(0, 0, 0, 0, 0, 0, 416, 416, 416, 416);
    va[8]  = mk(100, 0, 0, 0, 0, 0, 516, 516, 516, 516);
    va[9]  = mk(511, 0, 0, 0, 0, 0, 927, 927, 927, 927);
    va[10] = mk(37, 0, 0, 0, 0, 0, 453, 453, 453, 453);
    va[11] = mk(200, 0, 0, 0, 0, 0, 616, 616, 616, 616);
    va[12] = mk(100, 256, 0, 0, 0, 0, 1243, 0, 516, 516);
    va[13] = mk(511, 32767, -32768, 0, 0, 0,
                1813, 41, 927, 927);
    va[14] = mk(200, 0, 0, -40, 0, 0, 616, 616, 1001, 231);
    va[15] = mk(50, 0, 0, 0, 16, 0, 312, 312, 620, 620);
    va[16] = mk(0, -3, 0, 0, 0, 0, 387, 445, 416, 416);
    va[17] = mk(0, 0, 0, 0, 0, 1, 432, 432, 432, 432);
    va[18] = mk(300, 0, 0, 0, 0, 1, 432, 432, 432, 432);
    va[19] = mk(10, 0, 0, 0, 0, 0, 426, 426, 426, 426);
    for (int i = 0; i < 7; i++) begin
      vb[i] = mk(0, 256, 0, 0, 0, 0,
                 64 * (i + 1), 64 * (i + 1),
                 64 * (i + 1), 64 * (i + 1));
    end
    vb[6] = mk(0, 256, 0, 0, 0, 0, 416, 416, 416, 416);
    for (int i = 7; i < 13; i++) begin
      vb[i] = mk(0, 256, 0, 0, 0, 0, 576, 256, 416, 416);
    end
    vb[13] = mk(0, 300, 0, 0, 0, 0, 999, 0, 416, 416);

    repeat (3) @(negedge clk);
    chk("rst frnt", int'(frnt_spd), 0);
    chk("rst bck", int'(bck_spd), 0);
    chk("rst lft", int'(lft_spd), 0);
    chk("rst rght", int'(rght_spd), 0);
    chk("rst spd_vld", int'(spd_vld), 0);
    chk("rst armed", int'(armed), 0);

    rst_n = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (spd_vld) n++;
      end
    end
    chk("off pulses", n, 0);
    chk("off frnt", int'(frnt_spd), 0);
    chk("off armed", int'(armed), 0);

    motors_off = 1'b0;
    vld_nopulse("arm", zv);
    chk("arm armed", int'(armed), 1);
    for (int i = 0; i < 20; i++) begin
      run_vec($sformatf("va%0d", i), va[i]);
    end

    @(negedge clk);
    motors_off = 1'b1;
    @(negedge clk);
    motors_off = 1'b0;
    chk("kill armed", int'(armed), 0);
    chk("kill frnt", int'(frnt_spd), 0);
    vld_nopulse("arm2", zv);
    run_vec("ramp2", mk(0, 0, 0, 0, 0, 0, 64, 64, 64, 64));

    @(negedge clk);
    vld = 1'b1;
    motors_off = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    chk("mo spd_vld", int'(spd_vld), 0);
    chk("mo armed", int'(armed), 0);
    chk("mo frnt", int'(frnt_spd), 0);
    chk("mo rght", int'(rght_spd), 0);
    motors_off = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (spd_vld) n++;
    end
    chk("mo dropped", n, 0);

    vld_nopulse("rearm", vb[0]);
    for (int i = 0; i < 14; i++) begin
      run_vec($sformatf("vb%0d", i), vb[i]);
    end

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst frnt", int'(frnt_spd), 0);
    chk("arst armed", int'(armed), 0);
    chk("arst spd_vld", int'(spd_vld), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
